// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: filters a reset request, releases active-low channel
// resets in index order after per-channel delays, and re-asserts them in reverse order.
module reset_sequencer #(
   parameter int                      N_CHAN     = 4,
   parameter int                      SHIFT      = 4,
   parameter int                      W_CTR      = 8,
   parameter logic [N_CHAN*W_CTR-1:0] DELAYS     = 32'h00_02_05_0a,
   parameter bit                      ASSERT_SEQ = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              force_rst,
   input  logic              sw_req,
   output logic [N_CHAN-1:0] chan_rst_n,
   output logic              busy,
   output logic              done
);
   localparam int               IDX_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CHAN - 1);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RELEASE = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_ASSERT  = 2'd3;

   logic [1:0]       state;
   logic [SHIFT-1:0] shift;
   logic [W_CTR-1:0] ctr;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] hi;
   logic             filter_ok;
   logic             accept_sw;
   logic             enter_assert;

   function automatic logic [W_CTR-1:0] delay_of(input logic [IDX_W-1:0] i);
      logic [W_CTR-1:0] d;
      d = '0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (i == IDX_W'(k)) d = DELAYS[k*W_CTR +: W_CTR];
      end
      return d;
   endfunction

   assign filter_ok    = shift[SHIFT-1];
   assign accept_sw    = sw_req && (state == S_RUN);
   assign enter_assert = ((state == S_RUN) && (force_rst || sw_req)) ||
                         ((state == S_RELEASE) && force_rst);
   assign busy         = (state != S_RUN);

   // Highest channel currently released: all of them in RUN, those below idx in RELEASE.
   always_comb begin
      hi = LAST;
      if (state == S_RELEASE) hi = idx - IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift      <= '0;
         state      <= S_HOLD;
         ctr        <= '0;
         idx        <= '0;
         chan_rst_n <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;

         if (force_rst || accept_sw) shift <= '0;
         else                        shift <= (shift << 1) | SHIFT'(1);

         // The entry edge already drops the highest released channel.
         if (enter_assert) begin
            if (!ASSERT_SEQ || ((state == S_RELEASE) && (idx == '0))) begin
               chan_rst_n <= '0;
               state      <= S_HOLD;
            end else begin
               chan_rst_n[hi] <= 1'b0;
               if (hi == '0) begin
                  state <= S_HOLD;
               end else begin
                  idx   <= hi - IDX_W'(1);
                  state <= S_ASSERT;
               end
            end
         end else begin
            case (state)
               S_HOLD: begin
                  chan_rst_n <= '0;
                  if (filter_ok && !force_rst) begin
                     ctr   <= delay_of('0);
                     idx   <= '0;
                     state <= S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  if (ctr != '0) begin
                     ctr <= ctr - W_CTR'(1);
                  end else begin
                     chan_rst_n[idx] <= 1'b1;
                     if (idx == LAST) begin
                        state <= S_RUN;
                        done  <= 1'b1;
                     end else begin
                        idx <= idx + IDX_W'(1);
                        ctr <= delay_of(idx + IDX_W'(1));
                     end
                  end
               end
               S_ASSERT: begin
                  chan_rst_n[idx] <= 1'b0;
                  if (idx == '0) state <= S_HOLD;
                  else           idx   <= idx - IDX_W'(1);
               end
               default: begin
                  chan_rst_n <= '1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: segment table for the default configuration plus hand-written
// sequences for a 2-channel, all-at-once assertion configuration, checked via a scoreboard.
module tb_reset_sequencer;
  typedef struct {
    int         n;
    logic       r;
    logic       f;
    logic       s;
    logic [3:0] ch;
    logic       b;
    logic       d;
    string      nm;
  } seg_t;

  typedef struct {
    int         at;
    int         unit;
    logic [3:0] ch;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       frc_a = 1'b0;
  logic       sw_a  = 1'b0;
  logic       frc_b = 1'b0;
  logic       sw_b  = 1'b0;
  logic [3:0] chan_a;
  logic       busy_a;
  logic       done_a;
  logic [1:0] chan_b;
  logic       busy_b;
  logic       done_b;

  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb[$];
  exp_t       cur;
  seg_t       tbl[$];
  logic [5:0] act;
  logic [5:0] req;

  reset_sequencer dut_a (
    .clk        (clk),
    .rst        (rst),
    .force_rst  (frc_a),
    .sw_req     (sw_a),
    .chan_rst_n (chan_a),
    .busy       (busy_a),
    .done       (done_a)
  );

  reset_sequencer #(
    .N_CHAN     (2),
    .DELAYS     (16'h0000),
    .ASSERT_SEQ (1'b0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .force_rst  (frc_b),
    .sw_req     (sw_b),
    .chan_rst_n (chan_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectations are due after edge 'at'; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      if (cur.unit == 0) act = {chan_a, busy_a, done_a};
      else               act = {2'b00, chan_b, busy_b, done_b};
      req = {cur.ch, cur.b, cur.d};
      n_checks++;
      if (cur.at != cyc || act !== req) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d: got chan/busy/done=%b/%b/%b required %b/%b/%b",
                 cur.nm, cyc, cur.at, act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic void add(input int n, input logic r, input logic f, input logic s,
                              input logic [3:0] ch, input logic b, input logic d,
                              input string nm);
    seg_t t;
    t.n = n; t.r = r; t.f = f; t.s = s; t.ch = ch; t.b = b; t.d = d; t.nm = nm;
    tbl.push_back(t);
  endfunction

  // Drive inputs for the next edge and queue the outputs required after it.
  task automatic step(input int unit, input logic r, input logic f, input logic s,
                      input logic [3:0] ch, input logic b, input logic d, input string nm);
    exp_t e;
    rst = r;
    if (unit == 0) begin
      frc_a = f;
      sw_a  = s;
    end else begin
      frc_b = f;
      sw_b  = s;
    end
    e.at = cyc + 1; e.unit = unit; e.ch = ch; e.b = b; e.d = d; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // Power-up: rst for 3 edges; ch0/1/2/3 at edges 16/22/25/26 after rst falls.
    add(3,  1, 0, 0, 4'b0000, 1, 0, "rst_state");
    add(15, 0, 0, 0, 4'b0000, 1, 0, "pwr_hold");
    add(6,  0, 0, 0, 4'b0001, 1, 0, "pwr_ch0");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "pwr_ch1");
    add(1,  0, 0, 0, 4'b0111, 1, 0, "pwr_ch2");
    add(1,  0, 0, 0, 4'b1111, 0, 1, "pwr_done");
    add(5,  0, 0, 0, 4'b1111, 0, 0, "pwr_run");
    // sw_req in RUN: reverse drop over 4 edges, re-release 16/22/25/26 edges later.
    add(1,  0, 0, 1, 4'b0111, 1, 0, "sw_drop3");
    add(1,  0, 0, 0, 4'b0011, 1, 0, "sw_drop2");
    add(1,  0, 0, 0, 4'b0001, 1, 0, "sw_drop1");
    add(13, 0, 0, 0, 4'b0000, 1, 0, "sw_hold");
    add(6,  0, 0, 0, 4'b0001, 1, 0, "sw_ch0");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "sw_ch1");
    add(1,  0, 0, 0, 4'b0111, 1, 0, "sw_ch2");
    add(1,  0, 0, 0, 4'b1111, 0, 1, "sw_done");
    add(3,  0, 0, 0, 4'b1111, 0, 0, "sw_run");
    // Same cycle with extra sw_req pulses during ASSERT and RELEASE: timing unchanged.
    add(1,  0, 0, 1, 4'b0111, 1, 0, "ign_drop3");
    add(1,  0, 0, 1, 4'b0011, 1, 0, "ign_sw_assert");
    add(1,  0, 0, 0, 4'b0001, 1, 0, "ign_drop1");
    add(13, 0, 0, 0, 4'b0000, 1, 0, "ign_hold");
    add(1,  0, 0, 0, 4'b0001, 1, 0, "ign_ch0");
    add(1,  0, 0, 1, 4'b0001, 1, 0, "ign_sw_release");
    add(4,  0, 0, 0, 4'b0001, 1, 0, "ign_ch0b");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "ign_ch1");
    add(1,  0, 0, 0, 4'b0111, 1, 0, "ign_ch2");
    add(1,  0, 0, 0, 4'b1111, 0, 1, "ign_done");
    add(3,  0, 0, 0, 4'b1111, 0, 0, "ign_run");
    // force_rst while ch1 counts, held 50 cycles; ch0 back SHIFT+delay0+2 edges after.
    add(1,  0, 0, 1, 4'b0111, 1, 0, "frc_drop3");
    add(1,  0, 0, 0, 4'b0011, 1, 0, "frc_drop2");
    add(1,  0, 0, 0, 4'b0001, 1, 0, "frc_drop1");
    add(13, 0, 0, 0, 4'b0000, 1, 0, "frc_hold");
    add(2,  0, 0, 0, 4'b0001, 1, 0, "frc_ch0");
    add(50, 0, 1, 0, 4'b0000, 1, 0, "frc_held");
    add(15, 0, 0, 0, 4'b0000, 1, 0, "frc_refill");
    add(6,  0, 0, 0, 4'b0001, 1, 0, "frc_ch0_again");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "frc_ch1");
    add(1,  0, 0, 0, 4'b0111, 1, 0, "frc_ch2");
    add(1,  0, 0, 0, 4'b1111, 0, 1, "frc_done");
    add(3,  0, 0, 0, 4'b1111, 0, 0, "frc_run");
    // force_rst on the edge ch2's counter is 0: ch2 stays low, ch1 then ch0 drop.
    add(1,  0, 0, 1, 4'b0111, 1, 0, "z_drop3");
    add(1,  0, 0, 0, 4'b0011, 1, 0, "z_drop2");
    add(1,  0, 0, 0, 4'b0001, 1, 0, "z_drop1");
    add(13, 0, 0, 0, 4'b0000, 1, 0, "z_hold");
    add(6,  0, 0, 0, 4'b0001, 1, 0, "z_ch0");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "z_ch1");
    add(1,  0, 1, 0, 4'b0001, 1, 0, "z_frc_at_zero");
    add(15, 0, 0, 0, 4'b0000, 1, 0, "z_hold2");
    add(6,  0, 0, 0, 4'b0001, 1, 0, "z_ch0b");
    add(3,  0, 0, 0, 4'b0011, 1, 0, "z_ch1b");
    add(1,  0, 0, 0, 4'b0111, 1, 0, "z_ch2b");
    add(1,  0, 0, 0, 4'b1111, 0, 1, "z_done");
    add(3,  0, 0, 0, 4'b1111, 0, 0, "z_run");

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(0, tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].ch, tbl[i].b, tbl[i].d, tbl[i].nm);
      end
    end

    // 2 channels, zero delays, all-at-once assertion.
    step(1, 0, 0, 0, 4'b0011, 0, 0, "b_run");
    step(1, 0, 0, 1, 4'b0000, 1, 0, "b_sw_drop_all");
    repeat (5) step(1, 0, 0, 0, 4'b0000, 1, 0, "b_hold");
    step(1, 0, 0, 0, 4'b0001, 1, 0, "b_ch0");
    step(1, 0, 0, 0, 4'b0011, 0, 1, "b_ch1_done");
    step(1, 0, 0, 0, 4'b0011, 0, 0, "b_run2");
    // force_rst on the edge ch1 would be released: ch1 stays low, ch0 drops with it.
    step(1, 0, 0, 1, 4'b0000, 1, 0, "b_sw_drop_all2");
    repeat (5) step(1, 0, 0, 0, 4'b0000, 1, 0, "b_hold2");
    step(1, 0, 0, 0, 4'b0001, 1, 0, "b_ch0_2");
    step(1, 0, 1, 0, 4'b0000, 1, 0, "b_frc_drop_all");
    repeat (5) step(1, 0, 0, 0, 4'b0000, 1, 0, "b_hold3");
    step(1, 0, 0, 0, 4'b0001, 1, 0, "b_ch0_3");
    step(1, 0, 0, 0, 4'b0011, 0, 1, "b_ch1_done3");
    step(1, 0, 0, 0, 4'b0011, 0, 0, "b_run3");

    @(negedge clk);
    if (chan_a !== 4'b1111) begin
      n_fail++;
      $display("FAIL end_a_chan: got %b required 1111", chan_a);
    end
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL end_a_busy: got %b required 0", busy_a);
    end
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL end_a_done: got %b required 0", done_a);
    end
    if (chan_b !== 2'b11) begin
      n_fail++;
      $display("FAIL end_b_chan: got %b required 11", chan_b);
    end
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      n_fail++;
      $display("FAIL end_b_busy_done: got %b/%b required 0/0", busy_b, done_b);
    end
    if (n_checks == 0) begin
      n_fail++;
      $display("FAIL no scoreboard checks evaluated");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
